// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Valid/ready ALU with a registered result stage. Arithmetic and
//            logic ops complete on the accept edge. Shifts by a non-zero
//            amount are done serially, one bit per clock.
// Ports    : clk, rst_n          clock, async active-low reset
//            in_valid/in_ready   request handshake
//            func_alu, mux_alu1, mux_alu2, src1, src2, imm   operation fields
//            out_valid/out_ready result handshake
//            alu_out, eq         registered result and equality flag
//            busy                serial shift in progress
// Revision : 1.0  initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int IMM_W  = 10,
  parameter int SIMM_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func_alu,
  input  logic             mux_alu1,
  input  logic             mux_alu2,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             eq,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_NAND  = 3'b001;
  localparam logic [2:0] OP_PASS1 = 3'b010;
  localparam logic [2:0] OP_EQL   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;

  localparam logic [1:0] SH_SHL = 2'b01;
  localparam logic [1:0] SH_SHR = 2'b10;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [SH_W-1:0]   count_q, count_d;
  logic [1:0]        shop_q, shop_d;   // func_alu[1:0] of the shift in flight
  logic              eqp_q, eqp_d;     // A==B of the shift in flight
  logic [WIDTH-1:0]  alu_out_q, alu_out_d;
  logic              eq_q, eq_d;
  logic              out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  op_a, op_b, res, shreg_next;
  logic [SH_W-1:0]   shamt;
  logic              a_eq_b, accept, is_shift;

  // One-bit shift step; bits [1:0] of the shift opcodes are 01/10/11.
  function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] v);
    case (op)
      SH_SHL:  shift_step = {v[WIDTH-2:0], 1'b0};
      SH_SHR:  shift_step = {1'b0, v[WIDTH-1:1]};
      default: shift_step = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign op_a     = mux_alu1 ? {imm, {(WIDTH-IMM_W){1'b0}}} : src1;
  assign op_b     = mux_alu2 ? {{(WIDTH-SIMM_W){imm[SIMM_W-1]}}, imm[SIMM_W-1:0]} : src2;
  assign shamt    = op_b[SH_W-1:0];
  assign a_eq_b   = (op_a == op_b);
  assign is_shift = func_alu[2] & (func_alu[1] | func_alu[0]);

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle result; a shift only lands here when its amount is zero.
  always_comb begin
    res = op_a;
    case (func_alu)
      OP_ADD:   res = op_a + op_b;
      OP_NAND:  res = ~(op_a & op_b);
      OP_PASS1: res = op_a;
      OP_EQL:   res = {{(WIDTH-1){1'b0}}, a_eq_b};
      OP_SUB:   res = op_a - op_b;
      default:  res = op_a;
    endcase
  end

  assign shreg_next = shift_step(shop_q, shreg_q);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    shop_d      = shop_q;
    eqp_d       = eqp_q;
    alu_out_d   = alu_out_q;
    eq_d        = eq_q;
    // Drain by default; a load below overrides this on the same edge.
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            shreg_d = op_a;
            count_d = shamt;
            shop_d  = func_alu[1:0];
            eqp_d   = a_eq_b;
          end else begin
            alu_out_d   = res;
            eq_d        = a_eq_b;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        // Output stage is empty here: entering SHIFT required it drained.
        shreg_d = shreg_next;
        count_d = count_q - 1'b1;
        if (count_q == SH_W'(1)) begin
          state_d     = IDLE;
          alu_out_d   = shreg_next;
          eq_d        = eqp_q;
          out_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      shop_q      <= '0;
      eqp_q       <= 1'b0;
      alu_out_q   <= '0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      shop_q      <= shop_d;
      eqp_q       <= eqp_d;
      alu_out_q   <= alu_out_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign eq        = eq_q;
  assign busy      = (state_q == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Self-checking bench for alu_pipe (WIDTH=16, IMM_W=10, SIMM_W=7).
//            A behavioural model tracks the expected outputs every cycle;
//            directed sequences pin known results, then random traffic runs.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  func_alu = '0;
  logic        mux_alu1 = 1'b0;
  logic        mux_alu2 = 1'b0;
  logic [15:0] src1 = '0;
  logic [15:0] src2 = '0;
  logic [9:0]  imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] alu_out;
  logic        eq;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_pipe #(.WIDTH(16), .IMM_W(10), .SIMM_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func_alu(func_alu), .mux_alu1(mux_alu1), .mux_alu2(mux_alu2),
    .src1(src1), .src2(src2), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .eq(eq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_busy = 0;      // clocks left before a pending shift result lands
  logic        m_ov = 1'b0;
  logic [15:0] m_data = '0;
  logic        m_eq = 1'b0;
  logic [15:0] m_pend = '0;
  logic        m_peq = 1'b0;

  function automatic logic [15:0] ref_result(input logic [2:0] f, input logic [15:0] a,
                                             input logic [15:0] b);
    int n;
    n = int'(b[3:0]);
    case (f)
      3'd0: ref_result = a + b;
      3'd1: ref_result = ~(a & b);
      3'd2: ref_result = a;
      3'd3: ref_result = (a == b) ? 16'd1 : 16'd0;
      3'd4: ref_result = a - b;
      3'd5: ref_result = a << n;
      3'd6: ref_result = a >> n;
      default: ref_result = 16'($signed(a) >>> n);
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : p_model
    int          n;
    logic [15:0] a, b, r, ld_d;
    logic        ld, ld_e, rdy;
    if (!rst_n) begin
      m_busy <= 0; m_ov <= 1'b0; m_data <= '0; m_eq <= 1'b0;
      m_pend <= '0; m_peq <= 1'b0;
    end else begin
      ld = 1'b0; ld_d = '0; ld_e = 1'b0;
      rdy = (m_busy == 0) && (!m_ov || out_ready);
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin ld = 1'b1; ld_d = m_pend; ld_e = m_peq; end
      end else if (in_valid && rdy) begin
        a = mux_alu1 ? (16'(imm) << 6) : src1;
        b = mux_alu2 ? 16'(int'($signed(imm[6:0]))) : src2;
        n = int'(b[3:0]);
        r = ref_result(func_alu, a, b);
        if (func_alu >= 3'd5 && n != 0) begin
          m_busy <= n; m_pend <= r; m_peq <= (a == b);
        end else begin
          ld = 1'b1; ld_d = r; ld_e = (a == b);
        end
      end
      if (ld) begin m_ov <= 1'b1; m_data <= ld_d; m_eq <= ld_e; end
      else if (out_ready) m_ov <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : p_cmp
    chk("in_ready",  in_ready,  (m_busy == 0) && (!m_ov || out_ready));
    chk("out_valid", out_valid, m_ov);
    chk("busy",      busy,      m_busy > 0);
    chk("alu_out",   alu_out,   m_data);
    chk("eq",        eq,        m_eq);
  end

  // ---------------- directed helpers ----------------
  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [2:0] f, input logic m1, input logic m2,
                       input logic [15:0] s1, input logic [15:0] s2, input logic [9:0] im);
    logic r;
    bit   done;
    done = 0;
    func_alu = f; mux_alu1 = m1; mux_alu2 = m2; src1 = s1; src2 = s2; imm = im;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) done = 1;
    end
    in_valid = 1'b0;
    if (!done) chk("issue_timeout", 0, 1);
  endtask

  // Waits for out_valid; lat counts falling edges, bcnt those with busy=1.
  task automatic wait_out(output logic [15:0] d, output logic e, output int lat, output int bcnt);
    bit got;
    got = 0; lat = 0; bcnt = 0; d = '0; e = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (out_valid) begin d = alu_out; e = eq; got = 1; end
    end
    if (!got) chk("result_timeout", 0, 1);
  endtask

  task automatic op_check(input string name, input logic [2:0] f, input logic m1, input logic m2,
                          input logic [15:0] s1, input logic [15:0] s2, input logic [9:0] im,
                          input logic [15:0] exp_d, input logic exp_e, input int exp_lat);
    logic [15:0] d;
    logic        e;
    int          lat, bcnt;
    issue(f, m1, m2, s1, s2, im);
    wait_out(d, e, lat, bcnt);
    chk({name, "_data"}, d, exp_d);
    chk({name, "_eq"}, e, exp_e);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, bcnt, exp_lat - 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_out", alu_out, 16'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eq", eq, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    op_check("add",     3'd0, 0, 0, 16'd10,   16'd20,   10'd0,          16'd30,   0, 1);
    op_check("add_wrap",3'd0, 0, 0, 16'hFFFF, 16'd1,    10'd0,          16'd0,    0, 1);
    op_check("addi",    3'd0, 0, 1, 16'd50,   16'd0,    10'b1111110100, 16'd38,   0, 1);
    op_check("eql_t",   3'd3, 0, 0, 16'd1234, 16'd1234, 10'd0,          16'd1,    1, 1);
    op_check("eql_f",   3'd3, 0, 0, 16'd1234, 16'd4321, 10'd0,          16'd0,    0, 1);
    op_check("lui",     3'd2, 1, 0, 16'd0,    16'd0,    10'b1100110011, 16'hCCC0, 0, 1);
    op_check("nand",    3'd1, 0, 0, 16'hAAAA, 16'h5555, 10'd0,          16'hFFFF, 0, 1);
    op_check("sub",     3'd4, 0, 0, 16'd5,    16'd7,    10'd0,          16'hFFFE, 0, 1);
    op_check("sra4",    3'd7, 0, 0, 16'h8000, 16'd4,    10'd0,          16'hF800, 0, 5);
    op_check("shl15",   3'd5, 0, 0, 16'h0001, 16'd15,   10'd0,          16'h8000, 0, 16);
    op_check("shr0",    3'd6, 0, 0, 16'h1234, 16'd0,    10'd0,          16'h1234, 0, 1);

    // Backpressure: first result held while the second waits to be accepted.
    out_ready = 1'b0;
    issue(3'd0, 0, 0, 16'd1, 16'd2, 10'd0);
    func_alu = 3'd0; src1 = 16'd5; src2 = 16'd6; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", alu_out, 16'd3);
      chk("bp_hold_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", alu_out, 16'd11);
    @(negedge clk);
    chk("bp_no_dup", out_valid, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a serial shift.
    issue(3'd6, 0, 0, 16'hFFFF, 16'd15, 10'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", alu_out, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_no_result", out_valid, 0);
    end
    @(posedge clk);
    #1;
    op_check("add_after_rst", 3'd0, 0, 0, 16'd3, 16'd4, 10'd0, 16'd7, 0, 1);

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      func_alu  = 3'($urandom_range(0, 7));
      mux_alu1  = ($urandom_range(0, 3) == 0);
      mux_alu2  = ($urandom_range(0, 3) == 0);
      src1      = 16'($urandom);
      src2      = ($urandom_range(0, 3) == 0) ? src1 : 16'($urandom);
      imm       = 10'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("final_idle", out_valid | busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (>= 8).
REQ-002 Parameter IMM_W, default 10, immediate field width (< WIDTH).
REQ-003 Parameter SIMM_W, default 7, signed-immediate field width, taken from imm[SIMM_W-1:0] (<= IMM_W).
REQ-004 Ports: clk  in  1  single clock, all state on rising edge.
REQ-005 Ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Ports: in_valid  in  1  operation request valid.
REQ-007 Ports: in_ready  out  1  block can accept an operation this cycle.
REQ-008 Ports: func_alu  in  3  opcode: 000 ADD, 001 NAND, 010 PASS1, 011 EQL, 100 SUB, 101 SHL, 110 SHR (logical), 111 SRA.
REQ-009 Ports: mux_alu1  in  1  operand-A select: 0 src1, 1 LUI immediate.
REQ-010 Ports: mux_alu2  in  1  operand-B select: 0 src2, 1 sign-extended immediate.
REQ-011 Ports: src1, src2  in  WIDTH  register operands; imm  in  IMM_W  immediate.
REQ-012 Ports: out_valid  out  1  result valid; out_ready  in  1  consumer accepts result.
REQ-013 Ports: alu_out  out  WIDTH  result; eq  out  1  equality flag; busy  out  1  multi-cycle shift in progress.

Function
REQ-014 Operand A SHALL be src1, or (mux_alu1=1) imm shifted left by WIDTH-IMM_W with zero fill.
REQ-015 Operand B SHALL be src2, or (mux_alu2=1) imm[SIMM_W-1:0] sign-extended to WIDTH.
REQ-016 Accept occurs on a rising edge where in_valid=1 and in_ready=1; operands and func_alu are sampled only then.
REQ-017 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1), combinationally.
REQ-018 Results: ADD A+B, SUB A-B, NAND ~(A&B), PASS1 A, EQL {WIDTH-1 zeros, A==B}; all modulo 2^WIDTH, carry discarded.
REQ-019 eq SHALL be registered with the result as (A==B) for every opcode.
REQ-020 Single-cycle ops (ADD, NAND, PASS1, EQL, SUB) and shifts with amount 0 load the output register on the accept edge; out_valid high the following cycle.
REQ-021 Shift amount = B[clog2(WIDTH)-1:0]; SHL zero fill, SHR zero fill, SRA replicates A[WIDTH-1].
REQ-022 State machine: IDLE, SHIFT. IDLE->SHIFT on accepting a shift with amount n>=1, loading shift register=A, count=n.
REQ-023 In SHIFT each edge shifts one bit and decrements count; the edge with count==1 loads the output register and returns to IDLE; out_valid thus rises n edges after accept.
REQ-024 busy SHALL equal (state==SHIFT); in_ready=0 throughout SHIFT.
REQ-025 While out_valid=1 and out_ready=0, alu_out and eq SHALL hold stable.
REQ-026 out_valid clears on an edge with out_ready=1 unless a new result loads on that same edge, in which case it stays 1 with new data (back-to-back throughput one per cycle).
REQ-027 Opcode/operand changes while not accepted SHALL have no effect on state or outputs.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, alu_out=0, eq=0, busy=0, count=0, independent of clk.
REQ-029 Reset during SHIFT or with an undrained result discards the operation; no result is produced after release.
REQ-030 First accept possible on the first rising edge after rst_n deasserts, in_ready=1 then.

Verification
REQ-031 ADD, out_ready=1: src1=10, src2=20 -> alu_out=30, eq=0, out_valid one cycle later; src1=0xFFFF, src2=1 -> alu_out=0.
REQ-032 ADDI: mux_alu2=1, src1=50, imm=10'b1111110100 -> alu_out=38; EQL src1=src2=1234 -> alu_out=1, eq=1; 1234 vs 4321 -> alu_out=0, eq=0.
REQ-033 LUI: func=PASS1, mux_alu1=1, imm=10'b1100110011 -> alu_out=0xCCC0; NAND 0xAAAA,0x5555 -> 0xFFFF.
REQ-034 SRA: src1=0x8000, src2=4 -> busy=1 and in_ready=0 for 4 cycles, out_valid 4 edges after accept, alu_out=0xF800; SHL 0x0001 by 15 -> 0x8000.
REQ-035 Backpressure: two back-to-back ADDs, out_ready=0 for 3 cycles -> first result held stable, in_ready=0, second accepted on the drain edge, both results delivered in order, none lost or duplicated.
REQ-036 Reset mid-shift: SHR 0xFFFF by 15, rst_n pulsed low 2 cycles into SHIFT -> out_valid, busy, alu_out=0 immediately; no result after release; next ADD 3+4 -> 7.
